// File: rtl/obs_trace_recorder.sv
// rtl/obs_trace_recorder.sv - run-length trace recorder for sampled DUT outputs
// Optional per-record start-cycle timestamp: define TRACE_TIMESTAMP_EN.
module obs_trace_recorder #(
  parameter int VEC_W  = 3,
  parameter int RUN_W  = 5,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic [VEC_W-1:0]          vec_in,
  output logic                      rec_valid,
  input  logic                      rec_ready,
`ifdef TRACE_TIMESTAMP_EN
  output logic [32+VEC_W+RUN_W-1:0] rec_data,
`else
  output logic [VEC_W+RUN_W-1:0]    rec_data,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      lost,
  output logic [ADDR_W:0]           rec_count
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int REC_W = 32 + VEC_W + RUN_W;
`else
  localparam int REC_W = VEC_W + RUN_W;
`endif
  localparam logic [RUN_W-1:0]  RUN_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   cur_vec;
  logic [RUN_W-1:0]   run;
  logic [REC_W-1:0]   mem [DEPTH];
  logic [ADDR_W:0]    wr_ptr, rd_ptr;
  logic               empty, full, pop, push, emit, enter;
  logic [REC_W-1:0]   emit_rec;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]        ts_cnt, run_ts;
  assign emit_rec = {run_ts, cur_vec, run};
`else
  assign emit_rec = {cur_vec, run};
`endif

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign rec_valid = !empty;
  assign rec_data  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
  assign pop       = rec_valid && rec_ready;
  assign enter     = start && (state == IDLE || state == DONE);
  assign emit      = (state == CAPTURE) && (stop || vec_in != cur_vec || run == RUN_MAX);
  assign push      = emit && (!full || pop);
  assign busy      = (state == CAPTURE) || (state == FLUSH);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = CAPTURE;
      CAPTURE:    if (stop)  state_nxt = FLUSH;
      FLUSH:      if (empty) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cur_vec   <= '0;
      run       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lost      <= 1'b0;
      rec_count <= '0;
    end else begin
      state <= state_nxt;
      if (enter) begin
        // Restart discards anything still buffered from the previous capture.
        cur_vec   <= vec_in;
        run       <= RUN_W'(1);
        lost      <= 1'b0;
        rec_count <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end else begin
        if (state == CAPTURE && !stop) begin
          if (emit) begin
            cur_vec <= vec_in;
            run     <= RUN_W'(1);
          end else begin
            run <= run + 1'b1;
          end
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (rec_count != CNT_MAX) rec_count <= rec_count + 1'b1;
        end
        if (emit && !push) lost <= 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= emit_rec;
  end

`ifdef TRACE_TIMESTAMP_EN
  // ts_cnt holds the index of the current cycle relative to the start cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ts_cnt <= '0;
      run_ts <= '0;
    end else if (enter) begin
      ts_cnt <= 32'd1;
      run_ts <= '0;
    end else if (state == CAPTURE) begin
      ts_cnt <= ts_cnt + 1'b1;
      if (emit && !stop) run_ts <= ts_cnt;
    end
  end
`endif

endmodule
